// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master issues start/a/b and observes the result, ser and status outputs.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ser_bit;
    logic             ser_valid;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ser_bit, ser_valid
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ser_bit, ser_valid
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B, LSB first, one full-subtractor step per clock.
// The borrow is registered between steps; diff/bout are held until the next completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-2:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             d_c;
    logic             bn_c;
    logic [WIDTH-1:0] res_full_c;

    // Full subtractor cell on the current LSBs plus the registered borrow.
    always_comb begin
        d_c        = 1'b0;
        bn_c       = 1'b0;
        res_full_c = '0;
        d_c        = sa_q[0] ^ sb_q[0] ^ br_q;
        bn_c       = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        res_full_c = {d_c, res_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        sa_q    <= bus.a;
                        sb_q    <= bus.b;
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
                    res_q <= res_full_c[WIDTH-1:1];
                    br_q  <= bn_c;
                    cnt_q <= cnt_q + CW'(1);
                    // Last bit: publish the assembled result and the final borrow together.
                    if (cnt_q == LAST) begin
                        diff_q  <= res_full_c;
                        bout_q  <= bn_c;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ser_valid = (state_q == ST_SHIFT);
    assign bus.ser_bit   = (state_q == ST_SHIFT) & d_c;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against a plain-arithmetic model.
module tb_serial_subtractor;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [W-1:0] prev_diff;
    logic         prev_bout;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one single-cycle start and observes W+2 cycles; performs no comparisons.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         output logic [W-1:0] ser, output logic [W-1:0] dff,
                         output logic bo, output logic [W-1:0] dpre,
                         output int nbusy, output int ndone, output int done_at,
                         output int nsv);
        ser = '0; dff = '0; bo = 1'b0; dpre = '0;
        nbusy = 0; ndone = 0; done_at = -1; nsv = 0;
        bus.a = ai; bus.b = bi; bus.start = 1'b1;
        for (int n = 1; n <= int'(W) + 2; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.ser_valid) begin
                nsv++;
                if (n - 1 < int'(W)) ser[n-1] = bus.ser_bit;
            end
            if (n == int'(W)) dpre = bus.diff;
            if (bus.done) begin
                ndone++;
                done_at = n;
                dff = bus.diff;
                bo = bus.bout;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bout, bus.ser_bit, bus.ser_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%0d bout=%b ser=%b sv=%b, required all 0",
                     bus.busy, bus.done, bus.diff, bus.bout, bus.ser_bit, bus.ser_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.diff !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b diff=%0d, required 0/0", bus.busy, bus.diff);
        end
        prev_diff = '0; prev_bout = 1'b0;
    endtask

    // Runs one op and compares everything observable against the arithmetic model.
    task automatic check_op(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi);
        logic [W-1:0] ser, dff, dpre, exp_d;
        logic bo, exp_b;
        int nbusy, ndone, done_at, nsv;
        exp_d = W'(ai - bi);
        exp_b = (ai < bi);
        do_op(ai, bi, ser, dff, bo, dpre, nbusy, ndone, done_at, nsv);
        checks++;
        if (dff !== exp_d || bo !== exp_b) begin
            errors++;
            $display("FAIL %s result a=%0d b=%0d: got diff=%0d bout=%b, required diff=%0d bout=%b",
                     name, ai, bi, dff, bo, exp_d, exp_b);
        end
        checks++;
        if (ser !== exp_d || nsv != int'(W)) begin
            errors++;
            $display("FAIL %s serial a=%0d b=%0d: got bits=%b valid_cycles=%0d, required bits=%b valid_cycles=%0d",
                     name, ai, bi, ser, nsv, exp_d, W);
        end
        checks++;
        if (nbusy != int'(W) + 1 || ndone != 1 || done_at != int'(W) + 1) begin
            errors++;
            $display("FAIL %s timing: got busy=%0d done=%0d done_at=%0d, required %0d/1/%0d",
                     name, nbusy, ndone, done_at, W + 1, W + 1);
        end
        checks++;
        if (dpre !== prev_diff) begin
            errors++;
            $display("FAIL %s hold: got diff before done=%0d, required %0d", name, dpre, prev_diff);
        end
        prev_diff = exp_d; prev_bout = exp_b;
    endtask

    task automatic test_directed();
        check_op("sub_9_5", 4'd9, 4'd5);
        check_op("sub_5_9", 4'd5, 4'd9);
        check_op("sub_0_1", 4'd0, 4'd1);
        check_op("sub_7_7", 4'd7, 4'd7);
        check_op("sub_0_0", 4'd0, 4'd0);
        check_op("sub_15_0", 4'd15, 4'd0);
    endtask

    task automatic test_start_ignored();
        int ndone;
        ndone = 0;
        bus.a = 4'd9; bus.b = 4'd5; bus.start = 1'b1;
        for (int n = 1; n <= int'(W) + 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (n == 2 || n == int'(W) + 1) begin
                bus.start = 1'b1; bus.a = 4'd3; bus.b = 4'd1;
            end
            if (bus.done) ndone++;
        end
        bus.start = 1'b0;
        checks++;
        if (bus.diff !== 4'd4 || bus.bout !== 1'b0 || ndone != 1) begin
            errors++;
            $display("FAIL ignore_start: got diff=%0d bout=%b done_pulses=%0d, required 4/0/1",
                     bus.diff, bus.bout, ndone);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle: got busy=%b, required 0", bus.busy);
        end
        prev_diff = 4'd4; prev_bout = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        bus.a = 4'd10; bus.b = 4'd3; bus.start = 1'b1;
        for (int n = 1; n <= 2 * (int'(W) + 2); n++) begin
            @(negedge clk);
            if (n == 2 * (int'(W) + 2)) bus.start = 1'b0;
            checks++;
            if (bus.busy !== ((n % (int'(W) + 2)) != 0) ||
                bus.done !== ((n % (int'(W) + 2)) == int'(W) + 1)) begin
                errors++; bad++;
                $display("FAIL back_to_back cycle %0d: got busy=%b done=%b", n, bus.busy, bus.done);
            end
        end
        checks++;
        if (bus.diff !== 4'd7 || bus.bout !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_result: got diff=%0d bout=%b, required 7/0", bus.diff, bus.bout);
        end
        prev_diff = 4'd7; prev_bout = 1'b0;
    endtask

    task automatic test_reset_mid();
        check_op("pre_reset", 4'd5, 4'd9);
        bus.a = 4'd9; bus.b = 4'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bout, bus.ser_bit, bus.ser_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b diff=%0d bout=%b ser=%b sv=%b, required all 0",
                     bus.busy, bus.done, bus.diff, bus.bout, bus.ser_bit, bus.ser_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0; prev_bout = 1'b0;
        @(negedge clk);
        check_op("post_reset", 4'd12, 4'd4);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            check_op("random", ra, rb);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        prev_diff = '0; prev_bout = 1'b0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
